line_burst_adapter: RTL and testbench

Downstream neighbour of the memory arbiter. Converts one 256-bit cacheline read or write request into a 4-beat, 64-bit burst transaction on the burst-memory port. Returns the assembled line and a single-cycle response to the arbiter. Only one transaction is outstanding at a time; the block sits between the arbiter and the top-level bmem_* pins.

---
 rtl/rv32i_types.sv | 18 +
 rtl/line_burst_adapter.sv | 153 +++++++++++++++
 tb/tb_line_burst_adapter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types and constants for the cacheline-to-burst memory path.
package rv32i_types;

    // Cacheline and burst geometry.
    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int BEATS       = LINE_W / BURST_W;
    localparam int OFFSET_BITS = 5;

    // Adapter transaction phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adapter_state_t;

endpackage

// File: rtl/line_burst_adapter.sv
// Converts one cacheline read/write request from the arbiter into a burst
// of BURST_W-bit beats on the memory port, then answers with a one-cycle
// resp_o. One transaction is in flight at a time.
//
// Handshake: the arbiter holds read_i/write_i as a level until resp_o pulses
// and must drop it the cycle after. On the memory side read_o/write_o act as
// a held request; every cycle resp_i is high moves exactly one beat (read:
// burst_i is valid; write: burst_o was taken), and cycles with resp_i low are
// waits in which beat index and burst_o are held.
module line_burst_adapter
    import rv32i_types::*;
#(
    parameter int LINE_W  = rv32i_types::LINE_W,
    parameter int BURST_W = rv32i_types::BURST_W,
    parameter int ADDR_W  = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,

    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam int NUM_BEATS = LINE_W / BURST_W;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    // Clearing the low offset bits with a mask (rather than slicing them
    // away) keeps every bit of address_i in use.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_BITS) - 1);

    adapter_state_t     state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               last_beat;

    assign last_beat = resp_i && (beat_cnt_q == LAST_BEAT);

    // Next-state, beat counter and line buffer update.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        addr_d     = addr_q;

        unique case (state_q)
            IDLE: begin
                // A write takes priority; a simultaneous read is dropped.
                if (write_i) begin
                    line_d     = line_i;
                    addr_d     = address_i & ALIGN_MASK;
                    beat_cnt_d = '0;
                    state_d    = WR;
                end else if (read_i) begin
                    // The buffer is left alone here so line_o keeps the
                    // previous line until the first new beat lands.
                    addr_d     = address_i & ALIGN_MASK;
                    beat_cnt_d = '0;
                    state_d    = RD;
                end
            end

            RD: begin
                if (resp_i) begin
                    line_d[beat_cnt_q*BURST_W +: BURST_W] = burst_i;
                    // Counter wraps to zero on the final beat.
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end

            WR: begin
                if (resp_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // Requests are still high this cycle, so they are not
                // sampled here; the arbiter drops them next cycle.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered state, counter, line buffer and latched address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            line_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
        end
    end

    // Port outputs decoded from the current phase.
    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        address_o = '0;
        burst_o   = '0;

        unique case (state_q)
            RD: begin
                read_o    = 1'b1;
                address_o = addr_q;
            end
            WR: begin
                write_o   = 1'b1;
                address_o = addr_q;
                // Held stable across wait cycles since beat_cnt_q only
                // advances on an accepted beat.
                burst_o   = line_q[beat_cnt_q*BURST_W +: BURST_W];
            end
            DONE: begin
                resp_o    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign line_o = line_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: reads, writes with waits, request
// priority, back-to-back transactions, mid-burst reset and stray beats.
module tb_line_burst_adapter;
    import rv32i_types::*;

    logic          clk;
    logic          rst;
    logic [255:0]  line_i;
    logic [255:0]  line_o;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [63:0]   burst_i;
    logic [63:0]   burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;

    int n_checks;
    int n_fail;

    line_burst_adapter dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled at negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        n_checks++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got r%b w%b resp%b want 000", read_o, write_o, resp_o);
        end
        n_checks++;
        if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
            n_fail++; $display("FAIL reset_data: addr %h burst %h line %h want zeros", address_o, burst_o, line_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        beats[0] = {8{8'h11}};
        beats[1] = {8{8'h22}};
        beats[2] = {8{8'h33}};
        beats[3] = {8{8'h44}};
        exp_line = {beats[3], beats[2], beats[1], beats[0]};

        address_i = 32'h6000_0014;
        read_i    = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (read_o !== 1'b1 || write_o !== 1'b0 || resp_o !== 1'b0) begin
                n_fail++; $display("FAIL read_ctrl cyc%0d: got r%b w%b resp%b want 100", i + 1, read_o, write_o, resp_o);
            end
            n_checks++;
            if (address_o !== 32'h6000_0000) begin
                n_fail++; $display("FAIL read_addr cyc%0d: got %h want 60000000", i + 1, address_o);
            end
            resp_i  = 1'b1;
            burst_i = beats[i];
            step();
        end
        resp_i = 1'b0;
        n_checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            n_fail++; $display("FAIL read_done cyc5: got resp%b r%b want resp1 r0", resp_o, read_o);
        end
        read_i = 1'b0;
        step();
        n_checks++;
        if (resp_o !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL read_after: got resp%b state %0d want resp0 IDLE", resp_o, dut.state_q);
        end
        n_checks++;
        if (line_o !== exp_line) begin
            n_fail++; $display("FAIL read_line: got %h want %h", line_o, exp_line);
        end
    endtask

    task automatic test_write_wait();
        logic [255:0] wl;
        int           pat [5];
        int           idx;
        wl  = 256'h0123456789abcdef_1122334455667788_99aabbccddeeff00_fedcba9876543210;
        pat = '{1, 0, 1, 1, 1};
        idx = 0;

        line_i    = wl;
        address_i = 32'h1234_567F;
        write_i   = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (write_o !== 1'b1 || read_o !== 1'b0 || resp_o !== 1'b0) begin
                n_fail++; $display("FAIL wr_ctrl cyc%0d: got w%b r%b resp%b want 100", c + 1, write_o, read_o, resp_o);
            end
            n_checks++;
            if (burst_o !== wl[idx*64 +: 64]) begin
                n_fail++; $display("FAIL wr_beat cyc%0d: got %h want %h", c + 1, burst_o, wl[idx*64 +: 64]);
            end
            n_checks++;
            if (address_o !== 32'h1234_5660) begin
                n_fail++; $display("FAIL wr_addr cyc%0d: got %h want 12345660", c + 1, address_o);
            end
            resp_i = (pat[c] != 0);
            step();
            if (pat[c] != 0) idx++;
        end
        resp_i = 1'b0;
        n_checks++;
        if (resp_o !== 1'b1 || write_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got resp%b w%b want resp1 w0", resp_o, write_o);
        end
        write_i = 1'b0;
        step();
        n_checks++;
        if (resp_o !== 1'b0 || line_o !== wl) begin
            n_fail++; $display("FAIL wr_after: got resp%b line %h want resp0 line %h", resp_o, line_o, wl);
        end
    endtask

    task automatic test_simultaneous();
        logic [255:0] wl;
        wl = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
              64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        line_i    = wl;
        address_i = 32'h0000_0040;
        read_i    = 1'b1;
        write_i   = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (write_o !== 1'b1 || read_o !== 1'b0) begin
                n_fail++; $display("FAIL sim_ctrl beat%0d: got w%b r%b want w1 r0", i, write_o, read_o);
            end
            resp_i  = 1'b1;
            burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
            step();
        end
        resp_i = 1'b0;
        n_checks++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) begin
            n_fail++; $display("FAIL sim_done: got resp%b r%b want resp1 r0", resp_o, read_o);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        step();
        n_checks++;
        if (line_o !== wl) begin
            n_fail++; $display("FAIL sim_line: got %h want %h", line_o, wl);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  beats [4];
        logic [255:0] wl;
        beats[0] = 64'h0101_0101_0101_0101;
        beats[1] = 64'h0202_0202_0202_0202;
        beats[2] = 64'h0303_0303_0303_0303;
        beats[3] = 64'h0404_0404_0404_0404;
        wl = {4{64'h5A5A_A5A5_F0F0_0F0F}};

        address_i = 32'h0000_1000;
        read_i    = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (resp_o !== 1'b0) begin
                n_fail++; $display("FAIL b2b_rd_resp beat%0d: got %b want 0", i, resp_o);
            end
            resp_i  = 1'b1;
            burst_i = beats[i];
            step();
        end
        resp_i = 1'b0;
        n_checks++;
        if (resp_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_rd_done: got %b want 1", resp_o);
        end
        read_i = 1'b0;
        step();
        n_checks++;
        if (dut.state_q !== IDLE || resp_o !== 1'b0 || read_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got state %0d resp%b r%b want IDLE 0 0", dut.state_q, resp_o, read_o);
        end
        n_checks++;
        if (line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin
            n_fail++; $display("FAIL b2b_rd_line: got %h", line_o);
        end
        line_i  = wl;
        write_i = 1'b1;
        step();
        n_checks++;
        if (dut.state_q !== WR || write_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_wr_start: got state %0d w%b want WR 1", dut.state_q, write_o);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (resp_o !== 1'b0) begin
                n_fail++; $display("FAIL b2b_wr_resp beat%0d: got %b want 0", i, resp_o);
            end
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        n_checks++;
        if (resp_o !== 1'b1) begin
            n_fail++; $display("FAIL b2b_wr_done: got %b want 1", resp_o);
        end
        write_i = 1'b0;
        step();
        n_checks++;
        if (resp_o !== 1'b0 || dut.state_q !== IDLE || line_o !== wl) begin
            n_fail++; $display("FAIL b2b_wr_after: got resp%b state %0d line %h", resp_o, dut.state_q, line_o);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] beats [4];
        beats[0] = 64'hC0DE_0000_0000_00A0;
        beats[1] = 64'hC0DE_0000_0000_00A1;
        beats[2] = 64'hC0DE_0000_0000_00A2;
        beats[3] = 64'hC0DE_0000_0000_00A3;

        address_i = 32'h8000_0020;
        read_i    = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
        end
        resp_i = 1'b0;
        rst    = 1'b1;
        step();
        n_checks++;
        if (read_o !== 1'b0 || resp_o !== 1'b0 || dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL rst_mid: got r%b resp%b state %0d want 0 0 IDLE", read_o, resp_o, dut.state_q);
        end
        n_checks++;
        if (line_o !== 256'h0 || address_o !== 32'h0 || dut.beat_cnt_q !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_data: got line %h addr %h cnt %0d want zeros", line_o, address_o, dut.beat_cnt_q);
        end
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (read_o !== 1'b1 || address_o !== 32'h8000_0020) begin
                n_fail++; $display("FAIL rst_rerd beat%0d: got r%b addr %h want 1 80000020", i, read_o, address_o);
            end
            resp_i  = 1'b1;
            burst_i = beats[i];
            step();
        end
        resp_i = 1'b0;
        n_checks++;
        if (resp_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_rerd_done: got %b want 1", resp_o);
        end
        read_i = 1'b0;
        step();
        n_checks++;
        if (line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin
            n_fail++; $display("FAIL rst_rerd_line: got %h", line_o);
        end
    endtask

    task automatic test_stray_resp();
        logic [255:0] held;
        held = {64'hC0DE_0000_0000_00A3, 64'hC0DE_0000_0000_00A2,
                64'hC0DE_0000_0000_00A1, 64'hC0DE_0000_0000_00A0};
        for (int i = 0; i < 3; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
            step();
            n_checks++;
            if (dut.state_q !== IDLE || dut.beat_cnt_q !== 2'd0) begin
                n_fail++; $display("FAIL stray_state cyc%0d: got state %0d cnt %0d want IDLE 0", i, dut.state_q, dut.beat_cnt_q);
            end
            n_checks++;
            if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== held) begin
                n_fail++; $display("FAIL stray_out cyc%0d: got r%b w%b resp%b line %h", i, read_o, write_o, resp_o, line_o);
            end
        end
        resp_i = 1'b0;
    endtask

    // Sequence of scenarios followed by the summary line.
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        @(negedge clk);

        test_reset();
        test_read();
        test_write_wait();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        test_stray_resp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
